mc_gain_fsm: RTL and testbench
==============================

MC_GAIN_FSM -- requirements
Module: mc_gain_fsm

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of audio channels processed per frame (1..16).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles per float-unit operation before abort.
REQ-003 SHALL use one clock and a synchronous, active-low reset, with ports:
- CLK  in  1  clock.
- RESET_N  in  1  synchronous active-low reset.
- READY  in  1  frame-start pulse.
- samples_in  in  32*NUM_CH  signed int samples, channel c at bits [32c+31:32c].
- gains_in  in  32*NUM_CH  IEEE-754 single gains, same packing.
- bypass  in  NUM_CH  per-channel bypass mask.
- samples_out  out  32*NUM_CH  processed samples, same packing.
- out_valid  out  1  one-cycle frame-complete pulse.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  one-cycle pulse when READY is seen while busy.
- timeout_err  out  1  sticky operation-timeout flag.
- s2_dataa, s2_datab  out  32  float-unit operands.
- s2_n  out  3  float-unit opcode.
- s2_start  out  1  float-unit start.
- s2_result  in  32  float-unit result.
- s2_done  in  1  float-unit done.

Function
REQ-004 SHALL use states IDLE, CH_SEL, ISSUE, WAIT, FIN.
REQ-005 IDLE with READY=1 SHALL snapshot samples_in, gains_in and bypass, clear ch to 0, and go to CH_SEL.
REQ-006 CH_SEL with bypass[ch]=1 SHALL write the snapshot sample to result slot ch unmodified, with no float-unit activity.
REQ-007 CH_SEL with bypass[ch]=0 SHALL set op=0 and go to ISSUE.
REQ-008 CH_SEL after a bypassed channel SHALL go to FIN if ch=NUM_CH-1, else increment ch and stay in CH_SEL.
REQ-009 Ops SHALL be:
- op0: FLOATIS, n=3'b010, dataa=sample.
- op1: FMULS, n=3'b100, dataa=op0 result, datab=gain[ch].
- op2: FIXSI, n=3'b001, dataa=op1 result.
REQ-010 ISSUE SHALL drive s2_start=1 for exactly one cycle with that op's operands and n, then go to WAIT.
REQ-011 WAIT SHALL hold s2_start=0 and hold s2_dataa, s2_datab and s2_n stable.
REQ-012 WAIT with s2_done=1 SHALL capture s2_result.
REQ-013 After capture, op0 and op1 SHALL go to ISSUE with op+1.
REQ-014 After capture, op2 SHALL write the result to slot ch, then go to FIN if ch=NUM_CH-1, else increment ch and go to CH_SEL.
REQ-015 s2_done SHALL be ignored outside WAIT.
REQ-016 A WAIT exceeding TIMEOUT cycles SHALL set timeout_err, write the unmodified sample to slot ch, and advance as in REQ-014.
REQ-017 FIN SHALL copy all result slots to samples_out simultaneously, pulse out_valid for one cycle, and go to IDLE.
REQ-018 samples_out SHALL change only in FIN and hold between frames.
REQ-019 READY while busy SHALL be ignored and SHALL pulse overrun.
REQ-020 READY in FIN SHALL count as busy; a frame is accepted only from IDLE.
REQ-021 Snapshot inputs SHALL be ignored after acceptance until the frame completes.
REQ-022 Timing per channel SHALL be: bypassed 1 cycle; processed 1 + 3*(1+L) cycles, where L is the WAIT cycles of each op.

Reset
REQ-023 With RESET_N=0 at a CLK edge, the block SHALL enter IDLE, set ch=0 and op=0, and clear all outputs, snapshots and result slots to 0, including timeout_err.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no out_valid.
REQ-025 After reset mid-frame, the first READY after release SHALL start a fresh frame.

Structure
REQ-026 A shared package SHALL hold the state enum, the opcode constants FLOATIS=3'b010, FMULS=3'b100 and FIXSI=3'b001, and the lane width 32.
REQ-027 The snapshot/result register file SHALL be one sub-module, mc_gain_lane_regs, with per-lane write and a bulk copy-out.

Verification
REQ-028 Bench SHALL use NUM_CH=4 and a float-unit model with done asserted 3 cycles after start.
REQ-029 All gains 2.0 (0x40000000), samples {100,-7,0,2147483647}, bypass=0, READY at cycle 0 -> out_valid at cycle 53; samples_out per model; exactly 12 start pulses.
REQ-030 bypass=4'b0101 with samples {10,20,30,40} and gains 0.5 -> samples_out {10,10,30,20}; 6 start pulses.
REQ-031 Model never asserts done on channel 2 op1 -> timeout_err=1 after 64 WAIT cycles; slot 2 = input sample; other channels correct.
REQ-032 READY re-pulsed at cycle 20 -> overrun pulse at cycle 20; a single out_valid; results unchanged.
REQ-033 RESET_N low at cycle 30 for 1 cycle -> no out_valid; all outputs 0.
REQ-034 After the reset in REQ-033, a new READY -> a normal frame with out_valid 53 cycles later.

Source files
------------

// File: rtl/mc_gain_pkg.sv
// Shared types and constants for the multichannel gain sequencer.
package mc_gain_pkg;

    localparam int unsigned LANE_W = 32;
    localparam int unsigned OPC_W  = 3;

    localparam logic [OPC_W-1:0] FLOATIS = 3'b010;
    localparam logic [OPC_W-1:0] FMULS   = 3'b100;
    localparam logic [OPC_W-1:0] FIXSI   = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        CH_SEL,
        ISSUE,
        WAIT,
        FIN
    } state_t;

    // One float-unit request: opcode plus both operands.
    typedef struct packed {
        logic [OPC_W-1:0]  n;
        logic [LANE_W-1:0] dataa;
        logic [LANE_W-1:0] datab;
    } fu_req_t;

endpackage

// File: rtl/mc_gain_lane_regs.sv
// Frame snapshot registers, per-lane result slots and the bulk copy-out to samples_out.
module mc_gain_lane_regs
    import mc_gain_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     snap_en,
    input  logic [LANE_W*NUM_CH-1:0] samples_in,
    input  logic [LANE_W*NUM_CH-1:0] gains_in,
    input  logic [NUM_CH-1:0]        bypass_in,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [LANE_W-1:0]        wr_data,
    input  logic                     copy_en,
    output logic [LANE_W*NUM_CH-1:0] snap_samples,
    output logic [LANE_W*NUM_CH-1:0] snap_gains,
    output logic [NUM_CH-1:0]        snap_bypass,
    output logic [LANE_W*NUM_CH-1:0] samples_out
);

    logic [LANE_W*NUM_CH-1:0] slots_q;
    logic [LANE_W*NUM_CH-1:0] slots_d;

    // Copy-out sees a write landing on the same edge, so the last lane is never one frame stale.
    always_comb begin
        slots_d = slots_q;
        if (wr_en) begin
            slots_d[LANE_W*wr_idx +: LANE_W] = wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            snap_samples <= '0;
            snap_gains   <= '0;
            snap_bypass  <= '0;
            slots_q      <= '0;
            samples_out  <= '0;
        end else begin
            if (snap_en) begin
                snap_samples <= samples_in;
                snap_gains   <= gains_in;
                snap_bypass  <= bypass_in;
            end
            slots_q <= slots_d;
            if (copy_en) begin
                samples_out <= slots_d;
            end
        end
    end

endmodule

// File: rtl/mc_gain_fsm.sv
// Per-frame gain sequencer: each lane is converted, scaled and converted back on a shared float unit.
module mc_gain_fsm
    import mc_gain_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     READY,
    input  logic [LANE_W*NUM_CH-1:0] samples_in,
    input  logic [LANE_W*NUM_CH-1:0] gains_in,
    input  logic [NUM_CH-1:0]        bypass,
    output logic [LANE_W*NUM_CH-1:0] samples_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout_err,
    output logic [LANE_W-1:0]        s2_dataa,
    output logic [LANE_W-1:0]        s2_datab,
    output logic [OPC_W-1:0]         s2_n,
    output logic                     s2_start,
    input  logic [LANE_W-1:0]        s2_result,
    input  logic                     s2_done
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] OP_FLT = 2'd0;
    localparam logic [1:0] OP_FIX = 2'd2;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ch_q, ch_d, ch_adv;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    fu_req_t           req_q, req_d;
    logic              start_q, start_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;
    state_t            adv_state;

    logic                     snap_en_c;
    logic                     wr_en_c;
    logic [LANE_W-1:0]        wr_data_c;
    logic                     copy_en_c;
    logic [LANE_W*NUM_CH-1:0] snap_samples;
    logic [LANE_W*NUM_CH-1:0] snap_gains;
    logic [NUM_CH-1:0]        snap_bypass;
    logic [LANE_W-1:0]        cur_sample;
    logic [LANE_W-1:0]        cur_gain;

    mc_gain_lane_regs #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_lane_regs (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .snap_en      (snap_en_c),
        .samples_in   (samples_in),
        .gains_in     (gains_in),
        .bypass_in    (bypass),
        .wr_en        (wr_en_c),
        .wr_idx       (ch_q),
        .wr_data      (wr_data_c),
        .copy_en      (copy_en_c),
        .snap_samples (snap_samples),
        .snap_gains   (snap_gains),
        .snap_bypass  (snap_bypass),
        .samples_out  (samples_out)
    );

    assign cur_sample = snap_samples[LANE_W*ch_q +: LANE_W];
    assign cur_gain   = snap_gains[LANE_W*ch_q +: LANE_W];
    assign adv_state  = (ch_q == LAST_CH) ? FIN : CH_SEL;
    assign ch_adv     = (ch_q == LAST_CH) ? ch_q : ch_q + IDX_W'(1);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            op_q        <= '0;
            wcnt_q      <= '0;
            req_q       <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            op_q        <= op_d;
            wcnt_q      <= wcnt_d;
            req_q       <= req_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        op_d      = op_q;
        wcnt_d    = wcnt_q;
        req_d     = req_q;
        terr_d    = terr_q;
        snap_en_c = 1'b0;
        wr_en_c   = 1'b0;
        wr_data_c = cur_sample;

        case (state_q)
            IDLE: begin
                if (READY) begin
                    snap_en_c = 1'b1;
                    ch_d      = '0;
                    state_d   = CH_SEL;
                end
            end
            CH_SEL: begin
                if (snap_bypass[ch_q]) begin
                    wr_en_c = 1'b1;
                    state_d = adv_state;
                    ch_d    = ch_adv;
                end else begin
                    op_d    = OP_FLT;
                    req_d   = '{n: FLOATIS, dataa: cur_sample, datab: '0};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (s2_done) begin
                    if (op_q == OP_FIX) begin
                        wr_en_c   = 1'b1;
                        wr_data_c = s2_result;
                        state_d   = adv_state;
                        ch_d      = ch_adv;
                    end else begin
                        op_d    = op_q + 2'd1;
                        req_d   = (op_q == OP_FLT)
                                ? '{n: FMULS, dataa: s2_result, datab: cur_gain}
                                : '{n: FIXSI, dataa: s2_result, datab: '0};
                        state_d = ISSUE;
                    end
                end else if (wcnt_q == WAIT_MAX) begin
                    // Abandoned op: the lane passes through untouched.
                    terr_d  = 1'b1;
                    wr_en_c = 1'b1;
                    state_d = adv_state;
                    ch_d    = ch_adv;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        copy_en_c   = (state_d == FIN);
        start_d     = (state_d == ISSUE);
        out_valid_d = (state_d == FIN);
        busy_d      = (state_d != IDLE);
    end

    assign s2_n        = req_q.n;
    assign s2_dataa    = req_q.dataa;
    assign s2_datab    = req_q.datab;
    assign s2_start    = start_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    // Flags the READY being dropped in the same cycle it arrives.
    assign overrun     = READY & busy_q;

endmodule

// File: tb/tb_mc_gain_fsm.sv
// Bench for mc_gain_fsm: IEEE-single float-unit model plus an arithmetic reference for each lane.
module tb_mc_gain_fsm;
    import mc_gain_pkg::*;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         READY = 1'b0;
    logic [127:0] samples_in = '0;
    logic [127:0] gains_in = '0;
    logic [3:0]   bypass = '0;
    logic [127:0] samples_out;
    logic         out_valid, busy, overrun, timeout_err;
    logic [31:0]  s2_dataa, s2_datab;
    logic [2:0]   s2_n;
    logic         s2_start;
    logic [31:0]  fu_res = '0;
    logic         fu_done = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    mc_gain_fsm #(.NUM_CH(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .READY(READY),
        .samples_in(samples_in), .gains_in(gains_in), .bypass(bypass),
        .samples_out(samples_out), .out_valid(out_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err),
        .s2_dataa(s2_dataa), .s2_datab(s2_datab), .s2_n(s2_n), .s2_start(s2_start),
        .s2_result(fu_res), .s2_done(fu_done)
    );

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [23:0] m;
        logic [28:0] rem;
        int e;
        if (r == 0.0) return 32'h0;
        d   = $realtobits(r);
        e   = int'(d[62:52]) - 1023 + 127;
        m   = {1'b0, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 24'd1;
        if (m[23]) begin
            e = e + 1;
            m = 24'd0;
        end
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic real s2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'h0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] sat_int(input real r);
        if (r >= 2147483648.0) return 32'h7fff_ffff;
        if (r < -2147483648.0) return 32'h8000_0000;
        return 32'($rtoi(r));
    endfunction

    function automatic logic [31:0] fu_compute(input logic [2:0] n, input logic [31:0] a, input logic [31:0] b);
        case (n)
            FLOATIS: return r2s(real'($signed(a)));
            FMULS:   return r2s(s2r(a) * s2r(b));
            FIXSI:   return sat_int(s2r(a));
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Reference lane result: scale in exact arithmetic, truncate toward zero, saturate.
    function automatic logic [31:0] ref_lane(input int s, input real g, input bit byp);
        if (byp) return 32'(s);
        return sat_int(real'(s) * g);
    endfunction

    // Float-unit model: done is high exactly 3 cycles after the start cycle.
    int   fu_starts = 0;
    int   kill_at = -1;
    int   fu_cnt = 0;
    bit   fu_kill = 1'b0;
    always @(posedge CLK) begin
        fu_done <= 1'b0;
        if (!RESET_N) begin
            fu_cnt  <= 0;
            fu_kill <= 1'b0;
        end else if (s2_start) begin
            fu_cnt    <= 2;
            fu_res    <= fu_compute(s2_n, s2_dataa, s2_datab);
            fu_kill   <= (fu_starts == kill_at);
            fu_starts <= fu_starts + 1;
        end else if (fu_cnt != 0) begin
            fu_cnt <= fu_cnt - 1;
            if (fu_cnt == 1 && !fu_kill) fu_done <= 1'b1;
        end
    end

    task automatic drive_frame(input logic [127:0] smp, input logic [127:0] gns, input logic [3:0] byp,
                               input int ready2_at, input int rst_at, input int budget,
                               output int lat, output int nvalid, output int nstart, output int nov,
                               output bit ov_hit, output bit early_chg, output bit rst_zero);
        logic [127:0] held;
        int base;
        @(posedge CLK); #1;
        samples_in = smp; gains_in = gns; bypass = byp; READY = 1'b1; RESET_N = 1'b1;
        base = fu_starts; held = samples_out;
        lat = -1; nvalid = 0; nov = 0; ov_hit = 0; early_chg = 0; rst_zero = 0;
        for (int k = 0; k < budget; k++) begin
            if (k > 0) READY = (k == ready2_at);
            if (k == 1) begin
                samples_in = {$urandom(), $urandom(), $urandom(), $urandom()};
                gains_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
                bypass     = 4'($urandom());
            end
            RESET_N = (k != rst_at);
            @(negedge CLK);
            if (out_valid) begin
                nvalid++;
                if (lat < 0) lat = k;
                held = samples_out;
            end else if (samples_out !== held) begin
                early_chg = 1;
            end
            if (overrun) begin
                nov++;
                if (k == ready2_at) ov_hit = 1;
            end
            if (rst_at >= 0 && k == rst_at + 1)
                rst_zero = (samples_out == '0 && !out_valid && !busy && !s2_start && s2_n == '0 &&
                            s2_dataa == '0 && s2_datab == '0 && !timeout_err && !overrun);
            @(posedge CLK); #1;
        end
        READY = 1'b0; RESET_N = 1'b1;
        nstart = fu_starts - base;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        tests++;
        if (samples_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: got out=%h v=%b busy=%b terr=%b expected all 0", samples_out, out_valid, busy, timeout_err);
        end
        tests++;
        if (s2_start !== 1'b0 || s2_n !== 3'd0 || s2_dataa !== 32'd0 || s2_datab !== 32'd0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_fu_port: got start=%b n=%b a=%h b=%h ov=%b expected all 0", s2_start, s2_n, s2_dataa, s2_datab, overrun);
        end
        @(posedge CLK); #1;
        RESET_N = 1'b1;
    endtask

    // Shared body for the fixed-pattern frames; every check is made right here.
    task automatic test_frame(input string name, input int s[4], input logic [31:0] gbits, input real g,
                              input logic [3:0] byp, input int ready2_at, input int exp_lat, input int exp_starts,
                              input int kill_slot);
        logic [127:0] smp, gns;
        int lat, nv, ns, nov;
        bit ovh, chg, rz;
        logic [31:0] exp;
        for (int c = 0; c < 4; c++) begin
            smp[32*c +: 32] = 32'(s[c]);
            gns[32*c +: 32] = gbits;
        end
        drive_frame(smp, gns, byp, ready2_at, -1, 200, lat, nv, ns, nov, ovh, chg, rz);
        tests++;
        if (lat !== exp_lat || nv !== 1) begin
            fails++;
            $display("FAIL %s_valid: got latency %0d count %0d expected latency %0d count 1", name, lat, nv, exp_lat);
        end
        tests++;
        if (ns !== exp_starts) begin
            fails++;
            $display("FAIL %s_starts: got %0d expected %0d", name, ns, exp_starts);
        end
        for (int c = 0; c < 4; c++) begin
            exp = (c == kill_slot) ? 32'(s[c]) : ref_lane(s[c], g, byp[c]);
            tests++;
            if (samples_out[32*c +: 32] !== exp) begin
                fails++;
                $display("FAIL %s_lane%0d: got %h expected %h", name, c, samples_out[32*c +: 32], exp);
            end
        end
        tests++;
        if (busy !== 1'b0 || chg) begin
            fails++;
            $display("FAIL %s_idle_hold: got busy=%b early_change=%b expected 0 0", name, busy, chg);
        end
        if (ready2_at >= 0) begin
            tests++;
            if (nov !== 1 || !ovh) begin
                fails++;
                $display("FAIL %s_overrun: got pulses %0d at_ready=%b expected 1 1", name, nov, ovh);
            end
        end
    endtask

    task automatic test_all_gain2();
        int s[4] = '{100, -7, 0, 2147483647};
        test_frame("gain2", s, 32'h4000_0000, 2.0, 4'b0000, -1, 53, 12, -1);
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL gain2_terr: got %b expected 0", timeout_err);
        end
    endtask

    task automatic test_bypass();
        int s[4] = '{10, 20, 30, 40};
        test_frame("bypass", s, 32'h3F00_0000, 0.5, 4'b0101, -1, 29, 6, -1);
    endtask

    task automatic test_timeout();
        int s[4] = '{5, -3, 1000, 77};
        kill_at = fu_starts + 7;
        test_frame("timeout", s, 32'h4000_0000, 2.0, 4'b0000, -1, 110, 11, 2);
        kill_at = -1;
        tests++;
        if (timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_flag: got %b expected 1", timeout_err);
        end
    endtask

    task automatic test_overrun();
        int s[4] = '{100, -7, 0, 2147483647};
        test_frame("overrun", s, 32'h4000_0000, 2.0, 4'b0000, 20, 53, 12, -1);
    endtask

    task automatic test_mid_reset();
        logic [127:0] smp = {32'd4, 32'd3, 32'd2, 32'd1};
        int lat, nv, ns, nov;
        bit ovh, chg, rz;
        drive_frame(smp, {4{32'h4000_0000}}, 4'b0000, -1, 30, 80, lat, nv, ns, nov, ovh, chg, rz);
        tests++;
        if (nv !== 0) begin
            fails++;
            $display("FAIL midreset_valid: got %0d pulses expected 0", nv);
        end
        tests++;
        if (!rz) begin
            fails++;
            $display("FAIL midreset_outputs: got nonzero outputs after reset expected all 0");
        end
        tests++;
        if (busy !== 1'b0 || samples_out !== '0) begin
            fails++;
            $display("FAIL midreset_idle: got busy=%b out=%h expected 0 0", busy, samples_out);
        end
    endtask

    task automatic test_after_reset();
        int s[4] = '{-1000, 3, 65536, -2};
        test_frame("postreset", s, 32'h4000_0000, 2.0, 4'b0000, -1, 53, 12, -1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int s[4];
            real g[4];
            logic [127:0] smp, gns;
            logic [3:0] byp;
            int lat, nv, ns, nov, exp_lat, exp_ns;
            bit ovh, chg, rz;
            byp = 4'($urandom());
            exp_lat = 1; exp_ns = 0;
            for (int c = 0; c < 4; c++) begin
                s[c] = int'($urandom_range(2097150, 0)) - 1048575;
                g[c] = real'($urandom_range(15, 1)) / 4.0;
                smp[32*c +: 32] = 32'(s[c]);
                gns[32*c +: 32] = r2s(g[c]);
                exp_lat += byp[c] ? 1 : 13;
                exp_ns  += byp[c] ? 0 : 3;
            end
            drive_frame(smp, gns, byp, -1, -1, 80, lat, nv, ns, nov, ovh, chg, rz);
            tests++;
            if (lat !== exp_lat || nv !== 1 || ns !== exp_ns) begin
                fails++;
                $display("FAIL rand%0d_timing: got lat=%0d valids=%0d starts=%0d expected %0d 1 %0d", f, lat, nv, ns, exp_lat, exp_ns);
            end
            for (int c = 0; c < 4; c++) begin
                tests++;
                if (samples_out[32*c +: 32] !== ref_lane(s[c], g[c], byp[c])) begin
                    fails++;
                    $display("FAIL rand%0d_lane%0d: got %h expected %h", f, c, samples_out[32*c +: 32], ref_lane(s[c], g[c], byp[c]));
                end
            end
            tests++;
            if (chg || busy !== 1'b0 || timeout_err !== 1'b0 || nov !== 0) begin
                fails++;
                $display("FAIL rand%0d_status: got early=%b busy=%b terr=%b ov=%0d expected 0 0 0 0", f, chg, busy, timeout_err, nov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_gain2();
        test_bypass();
        test_timeout();
        test_overrun();
        test_mid_reset();
        test_after_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
